// File: rtl/down_timer.sv
// down_timer: loadable down-counting timer.
// Counts a preloaded value down to 1, emits a one-cycle tick on the terminal
// decrement, then either stops (one-shot) or reloads (auto mode).
//
// state | meaning
// IDLE  | stopped; nothing loaded, or a zero value was loaded
// RUN   | counting down on every enabled cycle
// DONE  | one-shot period expired; held until the next load or reset
module down_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             ld,
  input  logic [WIDTH-1:0] v,
  input  logic             auto,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_reload;
  logic             r_auto;

  // Load, count-down and terminal handling; load outranks counting in any state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_reload <= '0;
      r_auto   <= 1'b0;
      count    <= '0;
      tick     <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (ld) begin
        r_reload <= v;
        r_auto   <= auto;
        count    <= v;
        // A zero load is treated as a stop rather than an immediate expiry.
        r_state  <= (v != '0) ? RUN : IDLE;
      end else if (r_state == RUN && en) begin
        if (count > ONE) begin
          count <= count - ONE;
        end else begin
          // Terminal: count never goes below 1 in RUN, so no underflow.
          tick <= 1'b1;
          if (r_auto) begin
            count <= r_reload;
          end else begin
            count   <= '0;
            r_state <= DONE;
          end
        end
      end
    end
  end

  // Status flags are pure decodes of the state register.
  always_comb begin
    busy = (r_state == RUN);
    done = (r_state == DONE);
  end

endmodule

// File: tb/tb_down_timer.sv
// Self-checking bench for down_timer. The reference model tracks the loaded
// period and the number of enabled cycles since the load, and derives the
// expected count/tick/busy/done from those with plain arithmetic.
module tb_down_timer;

  logic       clk;
  logic       rst;
  logic       en;
  logic       ld;
  logic [7:0] v;
  logic       auto;
  logic [7:0] count;
  logic       tick;
  logic       busy;
  logic       done;

  int n_checks;
  int n_errors;

  // reference model state
  bit m_active;   // a nonzero period is loaded
  int m_p;        // loaded period
  int m_n;        // enabled cycles elapsed since load
  bit m_auto;
  bit m_tick;

  down_timer #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .en(en), .ld(ld), .v(v), .auto(auto),
    .count(count), .tick(tick), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit m_running();
    return m_active && (m_auto || m_n < m_p);
  endfunction

  function automatic int exp_count();
    if (!m_active) return m_p;
    if (m_auto) return m_p - (m_n % m_p);
    return m_p - m_n;
  endfunction

  function automatic bit exp_busy();
    return m_running();
  endfunction

  function automatic bit exp_done();
    return m_active && !m_auto && (m_n == m_p);
  endfunction

  // Drive one cycle of inputs, advance the model on the edge, sample #1 later.
  task automatic cyc(input bit r, input bit l, input bit e, input logic [7:0] vv, input bit a);
    @(negedge clk);
    rst = r; ld = l; en = e; v = vv; auto = a;
    @(posedge clk);
    if (!r) begin
      m_active = 0; m_p = 0; m_n = 0; m_auto = 0; m_tick = 0;
    end else if (l) begin
      m_p = vv; m_n = 0; m_auto = a; m_active = (vv != 0); m_tick = 0;
    end else if (e && m_running()) begin
      m_n++;
      m_tick = ((m_n % m_p) == 0);
    end else begin
      m_tick = 0;
    end
    #1;
  endtask

  task automatic test_reset();
    cyc(1, 1, 0, 8'd9, 1'b1);
    cyc(1, 0, 1, 8'd0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      cyc(0, 1, 1, 8'h55, 1'b1);
      n_checks++;
      if (count !== 8'd0 || tick !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
        n_errors++;
        $display("FAIL reset[%0d]: got count=%0d tick=%b busy=%b done=%b, want 0/0/0/0", i, count, tick, busy, done);
      end
    end
  endtask

  task automatic test_one_shot();
    int exp_seq [5] = '{4, 3, 2, 1, 0};
    cyc(1, 1, 0, 8'd5, 1'b0);
    n_checks++;
    if (count !== 8'd5 || busy !== 1'b1 || tick !== 1'b0) begin
      n_errors++;
      $display("FAIL oneshot_load: got count=%0d busy=%b tick=%b, want 5/1/0", count, busy, tick);
    end
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 1, 8'd0, 1'b0);
      n_checks++;
      if (count !== 8'(exp_seq[i]) || tick !== (i == 4) || done !== (i == 4) || busy !== (i != 4)) begin
        n_errors++;
        $display("FAIL oneshot_seq[%0d]: got count=%0d tick=%b done=%b busy=%b, want %0d/%b/%b/%b",
                 i, count, tick, done, busy, exp_seq[i], (i == 4), (i == 4), (i != 4));
      end
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 1, 8'd0, 1'b0);
      n_checks++;
      if (count !== 8'd0 || tick !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin
        n_errors++;
        $display("FAIL oneshot_hold[%0d]: got count=%0d tick=%b done=%b busy=%b, want 0/0/1/0", i, count, tick, done, busy);
      end
    end
  endtask

  task automatic test_auto_reload();
    int exp_seq [10] = '{3, 2, 1, 3, 2, 1, 3, 2, 1, 3};
    for (int i = 0; i < 10; i++) begin
      if (i == 0) cyc(1, 1, 0, 8'd3, 1'b1);
      else        cyc(1, 0, 1, 8'd0, 1'b0);
      n_checks++;
      if (count !== 8'(exp_seq[i]) || tick !== (i == 3 || i == 6 || i == 9) || busy !== 1'b1) begin
        n_errors++;
        $display("FAIL auto_seq[%0d]: got count=%0d tick=%b busy=%b, want %0d/%b/1",
                 i + 1, count, tick, busy, exp_seq[i], (i == 3 || i == 6 || i == 9));
      end
    end
  endtask

  task automatic test_pause();
    bit pat [6] = '{1, 0, 0, 1, 1, 1};
    int exp_seq [6] = '{3, 3, 3, 2, 1, 0};
    cyc(1, 1, 0, 8'd4, 1'b0);
    n_checks++;
    if (count !== 8'd4) begin
      n_errors++;
      $display("FAIL pause_load: got count=%0d, want 4", count);
    end
    for (int i = 0; i < 6; i++) begin
      cyc(1, 0, pat[i], 8'd0, 1'b0);
      n_checks++;
      if (count !== 8'(exp_seq[i]) || tick !== (i == 5) || tick !== m_tick) begin
        n_errors++;
        $display("FAIL pause_seq[%0d]: got count=%0d tick=%b, want %0d/%b", i, count, tick, exp_seq[i], (i == 5));
      end
    end
  endtask

  task automatic test_load_priority();
    cyc(1, 1, 0, 8'd2, 1'b1);
    cyc(1, 0, 1, 8'd0, 1'b0);
    n_checks++;
    if (count !== 8'd1) begin
      n_errors++;
      $display("FAIL ldprio_setup: got count=%0d, want 1", count);
    end
    cyc(1, 1, 1, 8'd7, 1'b0);
    n_checks++;
    if (count !== 8'd7 || tick !== 1'b0 || busy !== 1'b1) begin
      n_errors++;
      $display("FAIL ldprio_terminal: got count=%0d tick=%b busy=%b, want 7/0/1", count, tick, busy);
    end
    // zero load while running stops the timer
    cyc(1, 0, 1, 8'd0, 1'b0);
    cyc(1, 1, 1, 8'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (count !== 8'd0 || tick !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
        n_errors++;
        $display("FAIL zero_load[%0d]: got count=%0d tick=%b busy=%b done=%b, want 0/0/0/0", i, count, tick, busy, done);
      end
      cyc(1, 0, 1, 8'd0, 1'b0);
    end
  endtask

  task automatic test_v1_auto();
    cyc(1, 1, 0, 8'd1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 1, 8'd0, 1'b0);
      n_checks++;
      if (count !== 8'd1 || tick !== 1'b1 || busy !== 1'b1) begin
        n_errors++;
        $display("FAIL v1_auto[%0d]: got count=%0d tick=%b busy=%b, want 1/1/1", i, count, tick, busy);
      end
    end
    cyc(1, 0, 0, 8'd0, 1'b0);
    n_checks++;
    if (tick !== 1'b0 || count !== 8'd1) begin
      n_errors++;
      $display("FAIL v1_pause: got count=%0d tick=%b, want 1/0", count, tick);
    end
  endtask

  task automatic test_v255();
    int ticks = 0;
    int bad = 0;
    cyc(1, 1, 0, 8'd255, 1'b1);
    for (int i = 1; i <= 600; i++) begin
      cyc(1, 0, 1, 8'd0, 1'b0);
      if (tick) ticks++;
      if (count === 8'd0 || tick !== ((i % 255) == 0) || count !== 8'(exp_count())) bad++;
    end
    n_checks++;
    if (ticks != 2 || bad != 0) begin
      n_errors++;
      $display("FAIL v255: got ticks=%0d bad_cycles=%0d, want ticks=2 bad_cycles=0", ticks, bad);
    end
  endtask

  task automatic test_random();
    bit r, l, e, a;
    logic [7:0] vv;
    for (int i = 0; i < 500; i++) begin
      r  = ($urandom_range(0, 60) != 0);
      l  = ($urandom_range(0, 9) == 0);
      e  = ($urandom_range(0, 3) != 0);
      a  = $urandom_range(0, 1);
      vv = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6));
      cyc(r, l, e, vv, a);
      n_checks++;
      if (count !== 8'(exp_count()) || tick !== m_tick || busy !== exp_busy() || done !== exp_done()) begin
        n_errors++;
        $display("FAIL random[%0d]: got count=%0d tick=%b busy=%b done=%b, want %0d/%b/%b/%b",
                 i, count, tick, busy, done, exp_count(), m_tick, exp_busy(), exp_done());
      end
    end
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    m_active = 0; m_p = 0; m_n = 0; m_auto = 0; m_tick = 0;
    rst = 0; ld = 0; en = 0; v = '0; auto = 0;
    test_reset();
    test_one_shot();
    test_auto_reload();
    test_pause();
    test_load_priority();
    test_v1_auto();
    test_v255();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
